// File: rtl/delayprog_pkg.sv
// delayprog_pkg
//   Shared types for the programmable edge-delay array.
//   mode_e  : per-channel edge mode (which edge direction receives the programmed delay)
//   state_e : per-channel sequencer state
//   edge_uses_dly() : tells whether an edge of the given direction is delayed by the
//                     programmed count (1) or passes after a single cycle (0).
package delayprog_pkg;

   typedef enum logic [1:0] {
      MODE_BOTH   = 2'b00,
      MODE_RISE   = 2'b01,
      MODE_FALL   = 2'b10,
      MODE_BYPASS = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   function automatic logic edge_uses_dly(input mode_e m, input logic rising);
      logic r;
      r = 1'b0;
      case (m)
         MODE_BOTH: r = 1'b1;
         MODE_RISE: r = rising;
         MODE_FALL: r = ~rising;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/delayprog_chan.sv
// delayprog_chan
//   One channel of the programmable edge-delay array. The input is sampled once,
//   then any difference between the sample and the output is held off for the
//   effective delay; if the input returns before the delay expires the edge is
//   dropped (inertial filtering).
//   Optional feature macro: DELAYPROG_GLITCH_FLAG_EN adds busy/glitch/glitch_clr.
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous reset, active low
//   i          in   channel input (may be asynchronous; single sample stage)
//   dly        in   programmed delay D (0 behaves as 1)
//   mode       in   edge mode (see mode_e)
//   glitch_clr in   clear sticky glitch flag (macro only)
//   busy       out  an edge is pending (macro only)
//   glitch     out  sticky: a pending edge was cancelled (macro only)
//   o          out  delayed output
module delayprog_chan
   import delayprog_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i,
   input  logic [DW-1:0] dly,
   input  logic [1:0]    mode,
`ifdef DELAYPROG_GLITCH_FLAG_EN
   input  logic          glitch_clr,
   output logic          busy,
   output logic          glitch,
`endif
   output logic          o
);

   localparam logic [DW-1:0] ONE = DW'(1);

   logic          i_q;
   logic [DW-1:0] cnt;
   logic [DW-1:0] dly_l;
   logic [DW-1:0] deff;
   state_e        state;

   // Edge direction is judged from the current output: o=0 means a rise is pending.
   always_comb begin
      deff = ONE;
      if (edge_uses_dly(mode_e'(mode), ~o) && (dly != '0)) begin
         deff = dly;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         i_q    <= 1'b0;
         o      <= 1'b0;
         cnt    <= '0;
         dly_l  <= '0;
         state  <= ST_IDLE;
`ifdef DELAYPROG_GLITCH_FLAG_EN
         glitch <= 1'b0;
`endif
      end else begin
         i_q <= i;
`ifdef DELAYPROG_GLITCH_FLAG_EN
         if (glitch_clr) begin
            glitch <= 1'b0;
         end
`endif
         case (state)
            ST_IDLE: begin
               if (i_q != o) begin
                  // Delay is latched here so later dly/mode changes leave this edge alone.
                  dly_l <= deff;
                  cnt   <= ONE;
                  if (deff == ONE) begin
                     o <= i_q;
                  end else begin
                     state <= ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               if (i_q == o) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
`ifdef DELAYPROG_GLITCH_FLAG_EN
                  // Placed after the clear so a simultaneous set wins.
                  glitch <= 1'b1;
`endif
               end else if (cnt == dly_l - ONE) begin
                  o     <= i_q;
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef DELAYPROG_GLITCH_FLAG_EN
   assign busy = (state == ST_COUNT);
`endif

endmodule

// File: rtl/delayprog_array.sv
// delayprog_array
//   CH independent programmable edge-delay channels (replacement for fixed delay cells).
//   Optional feature macro: DELAYPROG_GLITCH_FLAG_EN adds busy/glitch/glitch_clr ports.
// Ports
//   CELCLK     in   clock, rising edge
//   CELRSTN    in   synchronous reset, active low
//   CELV/CELG/CELSUB in  supply/ground/substrate pins, no logic function
//   i          in   [CH]     channel inputs
//   dly        in   [CH*DW]  delay per channel, channel n at [n*DW +: DW]
//   mode       in   [CH*2]   edge mode per channel, channel n at [2n +: 2]
//   o          out  [CH]     delayed outputs
//   busy       out  [CH]     pending edge (macro only)
//   glitch     out  [CH]     sticky cancelled-edge flag (macro only)
//   glitch_clr in   [CH]     glitch clear (macro only)
module delayprog_array
   import delayprog_pkg::*;
#(
   parameter int CH = 4,
   parameter int DW = 8
) (
   input  logic             CELCLK,
   input  logic             CELRSTN,
   input  logic             CELV,
   input  logic             CELG,
   input  logic             CELSUB,
   input  logic [CH-1:0]    i,
   input  logic [CH*DW-1:0] dly,
   input  logic [CH*2-1:0]  mode,
`ifdef DELAYPROG_GLITCH_FLAG_EN
   output logic [CH-1:0]    busy,
   output logic [CH-1:0]    glitch,
   input  logic [CH-1:0]    glitch_clr,
`endif
   output logic [CH-1:0]    o
);

   // Power pins exist only for symbol compatibility.
   logic unused_pins;
   assign unused_pins = CELV ^ CELG ^ CELSUB;

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_chan
         delayprog_chan #(
            .DW(DW)
         ) u_chan (
            .clk        (CELCLK),
            .rst_n      (CELRSTN),
            .i          (i[gi]),
            .dly        (dly[gi*DW +: DW]),
            .mode       (mode[2*gi +: 2]),
`ifdef DELAYPROG_GLITCH_FLAG_EN
            .glitch_clr (glitch_clr[gi]),
            .busy       (busy[gi]),
            .glitch     (glitch[gi]),
`endif
            .o          (o[gi])
         );
      end
   endgenerate

endmodule
